vm_change_dispenser: RTL and testbench
======================================

VM_CHANGE_DISPENSER -- requirements
Module: vm_change_dispenser

Interface
REQ-001 SHALL have parameter INIT_COUNT, default 10: coin count loaded per denomination at reset.
REQ-002 SHALL have parameter CNT_W, default 8: width of the inventory and plan counters.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port change_req  input  1  request to pay out change_amount; sampled only in IDLE.
REQ-006 SHALL have port change_amount  input  8  change value in units.
REQ-007 SHALL have port change_ack  input  1  coin taken; completes the current coin handshake.
REQ-008 SHALL have port o_change_denomination_code  output  4  code of the coin offered: 1=1u, 2=2u, 3=5u, 4=10u.
REQ-009 SHALL have port o_change_valid  output  1  a coin is offered on o_change_denomination_code.
REQ-010 SHALL have port o_no_change  output  1  one-cycle pulse: exact change impossible.
REQ-011 SHALL have port o_done  output  1  one-cycle pulse: payout complete.
REQ-012 SHALL have port o_busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, CHECK, DISPENSE, DONE, NOCHG.
REQ-014 IDLE with change_req=1 SHALL latch change_amount as rem and enter CHECK; change_req outside IDLE SHALL be ignored.
REQ-015 CHECK SHALL last exactly 4 cycles, one denomination per cycle in order 10,5,2,1: plan[d]=min(rem/d, inv[d]); rem=rem-plan[d]*d.
REQ-016 After the 4th CHECK cycle: rem==0 -> DISPENSE; rem!=0 -> NOCHG.
REQ-017 NOCHG SHALL assert o_no_change for one cycle, leave inventory unchanged, then return to IDLE.
REQ-018 DISPENSE SHALL offer the largest denomination with plan>0 and hold o_change_valid and the code stable until change_ack.
REQ-019 On o_change_valid & change_ack, that denomination's plan and inv SHALL each decrement by 1.
REQ-020 change_ack without o_change_valid SHALL be ignored.
REQ-021 When all plans are 0, DISPENSE SHALL enter DONE; DONE SHALL pulse o_done for one cycle and return to IDLE.
REQ-022 change_amount=0 SHALL pass through CHECK, offer no coins, and pulse o_done.
REQ-023 Latency: request sampled at edge N -> first o_change_valid high after edge N+5, or o_no_change high after edge N+5.
REQ-024 o_change_valid SHALL be 0 outside DISPENSE, and o_change_denomination_code SHALL be 0 whenever o_change_valid=0.

Reset
REQ-025 rst=0 SHALL immediately force IDLE, all outputs to 0, all plans to 0, and every inv to INIT_COUNT, including mid-payout.
REQ-026 After reset release, the first change_req SHALL be accepted on the first rising edge.

Configuration
REQ-027 Macro VM_CHANGE_REFILL_EN defined SHALL add the inputs refill_valid (1), refill_code (4) and refill_count (CNT_W).
REQ-028 With VM_CHANGE_REFILL_EN, a refill_valid cycle SHALL add refill_count to inv[refill_code], saturating at 2^CNT_W-1, in any state.
REQ-029 With VM_CHANGE_REFILL_EN, a refill_code outside 1..4 SHALL be ignored.
REQ-030 With VM_CHANGE_REFILL_EN, a refill and a dispense decrement on the same denomination in the same cycle SHALL give inv+count-1, saturated.
REQ-031 Without VM_CHANGE_REFILL_EN, the refill ports SHALL be absent and inventory SHALL only decrease until reset.

Verification
REQ-032 INIT_COUNT=10, amount=18, ack every cycle -> codes 4,3,2,1 in order, then o_done; inv becomes 9,9,9,9.
REQ-033 After 10 payouts of 10, amount=20 -> ten10 exhausted, so four code-3 coins (5u) then o_done.
REQ-034 inv5=inv2=inv1=0, inv10=5, amount=13 -> o_no_change pulse 5 cycles after request; inv unchanged; no o_change_valid.
REQ-035 change_ack held low 3 cycles during a coin -> code and valid stable for those cycles; exactly one decrement on ack.
REQ-036 rst=0 between the 2nd and 3rd coin of amount=18 -> outputs 0 asynchronously, inv all 10, o_busy=0.
REQ-037 With VM_CHANGE_REFILL_EN: refill code 3 count 250 when inv5=10 -> inv5=255 (saturated).

Source files
------------

// File: rtl/vm_change_dispenser_if.sv
// Coin dispenser request/payout bundle shared by the vending controller and the dispenser.
interface vm_change_dispenser_if;

    logic       change_req;
    logic [7:0] change_amount;
    logic       change_ack;
    logic [3:0] o_change_denomination_code;
    logic       o_change_valid;
    logic       o_no_change;
    logic       o_done;
    logic       o_busy;

    modport master (
        output change_req,
        output change_amount,
        output change_ack,
        input  o_change_denomination_code,
        input  o_change_valid,
        input  o_no_change,
        input  o_done,
        input  o_busy
    );

    modport slave (
        input  change_req,
        input  change_amount,
        input  change_ack,
        output o_change_denomination_code,
        output o_change_valid,
        output o_no_change,
        output o_done,
        output o_busy
    );

endinterface

// File: rtl/vm_change_dispenser.sv
// Change dispenser: plans an exact payout from a four-denomination coin inventory
// (10,5,2,1 units, greedy largest-first), then hands coins out one per handshake.
// Optional feature macro VM_CHANGE_REFILL_EN adds refill ports that top up the inventory.
module vm_change_dispenser #(
    parameter int unsigned INIT_COUNT = 10,
    parameter int unsigned CNT_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
`ifdef VM_CHANGE_REFILL_EN
    input  logic               refill_valid,
    input  logic [3:0]         refill_code,
    input  logic [CNT_W-1:0]   refill_count,
`endif
    vm_change_dispenser_if.slave bus
);

    localparam int unsigned AMT_W = 8;
    localparam int unsigned MW    = (CNT_W > AMT_W) ? CNT_W : AMT_W;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CHECK    = 3'd1;
    localparam logic [2:0] DISPENSE = 3'd2;
    localparam logic [2:0] DONE     = 3'd3;
    localparam logic [2:0] NOCHG    = 3'd4;

    // Index 0..3 maps to 1u, 2u, 5u, 10u; the coin code is index+1.
    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [AMT_W-1:0] rem;
    logic [1:0]       step;
    logic [1:0]       cur_idx;
    logic [CNT_W-1:0] plan     [4];
    logic [CNT_W-1:0] inv      [4];
    logic [CNT_W-1:0] inv_next [4];
    logic [CNT_W:0]   inv_sum  [4];

    logic [1:0]       chk_idx;
    logic [AMT_W-1:0] chk_val;
    logic [AMT_W-1:0] chk_q;
    logic [MW-1:0]    chk_take;
    logic [AMT_W-1:0] chk_rem_next;

    logic             any_plan;
    logic [1:0]       sel_idx;
    logic             take_coin;

    assign take_coin = bus.o_change_valid & bus.change_ack;

    // One greedy planning step per CHECK cycle, largest denomination first.
    always_comb begin
        chk_idx = ~step;
        case (chk_idx)
            2'd3:    begin chk_val = 8'd10; chk_q = rem / 8'd10; end
            2'd2:    begin chk_val = 8'd5;  chk_q = rem / 8'd5;  end
            2'd1:    begin chk_val = 8'd2;  chk_q = rem / 8'd2;  end
            default: begin chk_val = 8'd1;  chk_q = rem;         end
        endcase
        chk_take = (MW'(chk_q) < MW'(inv[chk_idx])) ? MW'(chk_q) : MW'(inv[chk_idx]);
        chk_rem_next = AMT_W'(32'(rem) - 32'(chk_take) * 32'(chk_val));
    end

    // Largest denomination still owed in the plan.
    always_comb begin
        any_plan = 1'b0;
        sel_idx  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (plan[i] != '0) begin
                any_plan = 1'b1;
                sel_idx  = 2'(i);
            end
        end
    end

    // Inventory update: optional saturating refill combined with a taken coin.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            inv_sum[i] = {1'b0, inv[i]};
`ifdef VM_CHANGE_REFILL_EN
            if (refill_valid && refill_code == 4'(i + 1)) begin
                inv_sum[i] = inv_sum[i] + {1'b0, refill_count};
            end
`endif
            if (take_coin && cur_idx == 2'(i)) begin
                inv_sum[i] = inv_sum[i] - (CNT_W+1)'(1);
            end
            inv_next[i] = inv_sum[i][CNT_W] ? '1 : inv_sum[i][CNT_W-1:0];
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (bus.change_req) state_next = CHECK;
            CHECK:    if (step == 2'd3) state_next = (chk_rem_next == '0) ? DISPENSE : NOCHG;
            DISPENSE: if (!bus.o_change_valid && !any_plan) state_next = DONE;
            DONE:     state_next = IDLE;
            NOCHG:    state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Planning datapath, inventory and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem     <= '0;
            step    <= '0;
            cur_idx <= '0;
            for (int i = 0; i < 4; i++) begin
                plan[i] <= '0;
                inv[i]  <= CNT_W'(INIT_COUNT);
            end
            bus.o_change_denomination_code <= '0;
            bus.o_change_valid             <= 1'b0;
            bus.o_no_change                <= 1'b0;
            bus.o_done                     <= 1'b0;
            bus.o_busy                     <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) inv[i] <= inv_next[i];
            bus.o_busy      <= (state_next != IDLE);
            bus.o_done      <= (state == DONE);
            bus.o_no_change <= (state == NOCHG);
            case (state)
                IDLE: begin
                    if (bus.change_req) begin
                        rem  <= bus.change_amount;
                        step <= 2'd0;
                        for (int i = 0; i < 4; i++) plan[i] <= '0;
                    end
                end
                CHECK: begin
                    plan[chk_idx] <= CNT_W'(chk_take);
                    rem           <= chk_rem_next;
                    step          <= step + 2'd1;
                end
                DISPENSE: begin
                    if (take_coin) begin
                        plan[cur_idx]                  <= plan[cur_idx] - CNT_W'(1);
                        bus.o_change_valid             <= 1'b0;
                        bus.o_change_denomination_code <= '0;
                    end else if (!bus.o_change_valid && any_plan) begin
                        bus.o_change_valid             <= 1'b1;
                        bus.o_change_denomination_code <= 4'(sel_idx) + 4'd1;
                        cur_idx                        <= sel_idx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Directed bench for vm_change_dispenser; refill scenario built when VM_CHANGE_REFILL_EN is defined.
module tb_vm_change_dispenser;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vm_change_dispenser_if bus();

`ifdef VM_CHANGE_REFILL_EN
    logic       refill_valid;
    logic [3:0] refill_code;
    logic [7:0] refill_count;
`endif

    vm_change_dispenser #(.INIT_COUNT(10), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef VM_CHANGE_REFILL_EN
        .refill_valid (refill_valid),
        .refill_code  (refill_code),
        .refill_count (refill_count),
`endif
        .bus          (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.change_req    = 1'b0;
        bus.change_amount = 8'd0;
        bus.change_ack    = 1'b0;
`ifdef VM_CHANGE_REFILL_EN
        refill_valid = 1'b0;
        refill_code  = 4'd0;
        refill_count = 8'd0;
`endif
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    // Issue one request with ack held high and record what comes out.
    task automatic run_payout(input logic [7:0] amt, output int ncoins,
                              output logic [3:0] codes [16], output int first_cyc,
                              output bit got_done, output bit got_nochg, output bit timed_out);
        ncoins = 0; first_cyc = -1; got_done = 0; got_nochg = 0; timed_out = 1;
        for (int i = 0; i < 16; i++) codes[i] = 4'd0;
        bus.change_ack    = 1'b1;
        bus.change_req    = 1'b1;
        bus.change_amount = amt;
        tick();
        bus.change_req = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            tick();
            if (bus.o_change_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (ncoins < 16) codes[ncoins] = bus.o_change_denomination_code;
                ncoins++;
            end
            if (bus.o_no_change && first_cyc < 0) first_cyc = cyc;
            if (bus.o_done)      begin got_done = 1;  timed_out = 0; break; end
            if (bus.o_no_change) begin got_nochg = 1; timed_out = 0; break; end
        end
        bus.change_ack = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] exp_inv;
        exp_inv = 8'd10;
        bus.change_req = 1'b0; bus.change_amount = 8'd0; bus.change_ack = 1'b0;
`ifdef VM_CHANGE_REFILL_EN
        refill_valid = 1'b0; refill_code = 4'd0; refill_count = 8'd0;
`endif
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        total++; if (bus.o_change_valid !== 1'b0) begin $display("FAIL reset_valid got=%0b want=0", bus.o_change_valid); bad++; end
        total++; if (bus.o_change_denomination_code !== 4'd0) begin $display("FAIL reset_code got=%0d want=0", bus.o_change_denomination_code); bad++; end
        total++; if (bus.o_busy !== 1'b0) begin $display("FAIL reset_busy got=%0b want=0", bus.o_busy); bad++; end
        total++; if (bus.o_done !== 1'b0 || bus.o_no_change !== 1'b0) begin $display("FAIL reset_pulses got done=%0b nochg=%0b want 0/0", bus.o_done, bus.o_no_change); bad++; end
        for (int i = 0; i < 4; i++) begin
            total++; if (dut.inv[i] !== exp_inv) begin $display("FAIL reset_inv%0d got=%0d want=%0d", i, dut.inv[i], exp_inv); bad++; end
        end
        do_reset();
    endtask

    task automatic test_basic();
        int n; int fc; bit d; bit nc; bit to;
        logic [3:0] codes [16];
        logic [3:0] exp_codes [4];
        exp_codes = '{4'd4, 4'd3, 4'd2, 4'd1};
        do_reset();
        run_payout(8'd18, n, codes, fc, d, nc, to);
        total++; if (to !== 1'b0 || d !== 1'b1) begin $display("FAIL basic18_done got done=%0b timeout=%0b want 1/0", d, to); bad++; end
        total++; if (fc !== 5) begin $display("FAIL basic18_latency got=%0d want=5", fc); bad++; end
        total++; if (n !== 4) begin $display("FAIL basic18_ncoins got=%0d want=4", n); bad++; end
        for (int i = 0; i < 4; i++) begin
            total++; if (codes[i] !== exp_codes[i]) begin $display("FAIL basic18_code%0d got=%0d want=%0d", i, codes[i], exp_codes[i]); bad++; end
        end
        for (int i = 0; i < 4; i++) begin
            total++; if (dut.inv[i] !== 8'd9) begin $display("FAIL basic18_inv%0d got=%0d want=9", i, dut.inv[i]); bad++; end
        end
        run_payout(8'd0, n, codes, fc, d, nc, to);
        total++; if (d !== 1'b1 || nc !== 1'b0 || n !== 0) begin $display("FAIL zero_amount got done=%0b nochg=%0b coins=%0d want 1/0/0", d, nc, n); bad++; end
        total++; if (dut.inv[3] !== 8'd9) begin $display("FAIL zero_amount_inv got=%0d want=9", dut.inv[3]); bad++; end
    endtask

    task automatic test_exhaust();
        int n; int fc; bit d; bit nc; bit to;
        logic [3:0] codes [16];
        do_reset();
        for (int k = 0; k < 10; k++) begin
            run_payout(8'd10, n, codes, fc, d, nc, to);
            total++; if (n !== 1 || codes[0] !== 4'd4 || d !== 1'b1) begin $display("FAIL pay10_%0d got coins=%0d code=%0d done=%0b want 1/4/1", k, n, codes[0], d); bad++; end
        end
        total++; if (dut.inv[3] !== 8'd0) begin $display("FAIL exhaust_inv10 got=%0d want=0", dut.inv[3]); bad++; end
        run_payout(8'd20, n, codes, fc, d, nc, to);
        total++; if (n !== 4 || d !== 1'b1) begin $display("FAIL pay20_count got coins=%0d done=%0b want 4/1", n, d); bad++; end
        for (int i = 0; i < 4; i++) begin
            total++; if (codes[i] !== 4'd3) begin $display("FAIL pay20_code%0d got=%0d want=3", i, codes[i]); bad++; end
        end
        total++; if (dut.inv[2] !== 8'd6) begin $display("FAIL pay20_inv5 got=%0d want=6", dut.inv[2]); bad++; end
    endtask

    task automatic test_nochg();
        int n; int fc; bit d; bit nc; bit to;
        int drain_err;
        logic [3:0] codes [16];
        logic [7:0] exp_inv [4];
        exp_inv = '{8'd0, 8'd0, 8'd0, 8'd5};
        drain_err = 0;
        do_reset();
        for (int k = 0; k < 10; k++) begin run_payout(8'd1, n, codes, fc, d, nc, to); if (!d || n != 1) drain_err++; end
        for (int k = 0; k < 10; k++) begin run_payout(8'd2, n, codes, fc, d, nc, to); if (!d || n != 1) drain_err++; end
        for (int k = 0; k < 10; k++) begin run_payout(8'd5, n, codes, fc, d, nc, to); if (!d || n != 1) drain_err++; end
        for (int k = 0; k < 5;  k++) begin run_payout(8'd10, n, codes, fc, d, nc, to); if (!d || n != 1) drain_err++; end
        total++; if (drain_err !== 0) begin $display("FAIL drain_payouts got errors=%0d want=0", drain_err); bad++; end
        run_payout(8'd13, n, codes, fc, d, nc, to);
        total++; if (nc !== 1'b1 || d !== 1'b0) begin $display("FAIL nochg13_pulse got nochg=%0b done=%0b want 1/0", nc, d); bad++; end
        total++; if (fc !== 5) begin $display("FAIL nochg13_latency got=%0d want=5", fc); bad++; end
        total++; if (n !== 0) begin $display("FAIL nochg13_coins got=%0d want=0", n); bad++; end
        total++; if (bus.o_busy !== 1'b0) begin $display("FAIL nochg13_busy got=%0b want=0", bus.o_busy); bad++; end
        for (int i = 0; i < 4; i++) begin
            total++; if (dut.inv[i] !== exp_inv[i]) begin $display("FAIL nochg13_inv%0d got=%0d want=%0d", i, dut.inv[i], exp_inv[i]); bad++; end
        end
        tick();
        total++; if (bus.o_no_change !== 1'b0) begin $display("FAIL nochg13_one_cycle got=%0b want=0", bus.o_no_change); bad++; end
    endtask

    task automatic test_ack_hold();
        bit found; bit d;
        found = 0; d = 0;
        do_reset();
        bus.change_ack    = 1'b0;
        bus.change_req    = 1'b1;
        bus.change_amount = 8'd5;
        tick();
        bus.change_req = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.o_change_valid) begin found = 1; break; end
        end
        total++; if (found !== 1'b1) begin $display("FAIL hold_first_coin got valid_seen=%0b want=1", found); bad++; end
        for (int k = 0; k < 3; k++) begin
            if (k == 0) begin bus.change_req = 1'b1; bus.change_amount = 8'd1; end
            tick();
            bus.change_req = 1'b0;
            total++; if (bus.o_change_valid !== 1'b1 || bus.o_change_denomination_code !== 4'd3) begin
                $display("FAIL hold_stable%0d got valid=%0b code=%0d want 1/3", k, bus.o_change_valid, bus.o_change_denomination_code); bad++; end
            total++; if (dut.inv[2] !== 8'd10 || bus.o_busy !== 1'b1) begin
                $display("FAIL hold_nodec%0d got inv5=%0d busy=%0b want 10/1", k, dut.inv[2], bus.o_busy); bad++; end
        end
        bus.change_ack = 1'b1;
        tick();
        bus.change_ack = 1'b0;
        total++; if (bus.o_change_valid !== 1'b0 || dut.inv[2] !== 8'd9) begin
            $display("FAIL hold_ack got valid=%0b inv5=%0d want 0/9", bus.o_change_valid, dut.inv[2]); bad++; end
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.o_done) begin d = 1; break; end
        end
        total++; if (d !== 1'b1) begin $display("FAIL hold_done got=%0b want=1", d); bad++; end
        repeat (3) tick();
        total++; if (dut.inv[0] !== 8'd10 || dut.inv[2] !== 8'd9 || bus.o_busy !== 1'b0) begin
            $display("FAIL hold_ignored_req got inv1=%0d inv5=%0d busy=%0b want 10/9/0", dut.inv[0], dut.inv[2], bus.o_busy); bad++; end
    endtask

    task automatic test_reset_mid();
        int seen; bit d;
        seen = 0; d = 0;
        do_reset();
        bus.change_ack    = 1'b1;
        bus.change_req    = 1'b1;
        bus.change_amount = 8'd18;
        tick();
        bus.change_req = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (bus.o_change_valid) seen++;
            if (seen == 3) break;
        end
        total++; if (seen !== 3) begin $display("FAIL midrst_reach got coins=%0d want=3", seen); bad++; end
        #2 rst = 1'b0;
        #1;
        total++; if (bus.o_change_valid !== 1'b0 || bus.o_change_denomination_code !== 4'd0) begin
            $display("FAIL midrst_outputs got valid=%0b code=%0d want 0/0", bus.o_change_valid, bus.o_change_denomination_code); bad++; end
        total++; if (bus.o_busy !== 1'b0) begin $display("FAIL midrst_busy got=%0b want=0", bus.o_busy); bad++; end
        for (int i = 0; i < 4; i++) begin
            total++; if (dut.inv[i] !== 8'd10 || dut.plan[i] !== 8'd0) begin
                $display("FAIL midrst_inv%0d got inv=%0d plan=%0d want 10/0", i, dut.inv[i], dut.plan[i]); bad++; end
        end
        repeat (2) tick();
        rst = 1'b1;
        bus.change_req    = 1'b1;
        bus.change_amount = 8'd1;
        tick();
        bus.change_req = 1'b0;
        total++; if (bus.o_busy !== 1'b1) begin $display("FAIL post_reset_accept got busy=%0b want=1", bus.o_busy); bad++; end
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus.o_done) begin d = 1; break; end
        end
        bus.change_ack = 1'b0;
        total++; if (d !== 1'b1 || dut.inv[0] !== 8'd9) begin
            $display("FAIL post_reset_payout got done=%0b inv1=%0d want 1/9", d, dut.inv[0]); bad++; end
    endtask

`ifdef VM_CHANGE_REFILL_EN
    task automatic test_refill();
        bit found;
        found = 0;
        do_reset();
        refill_valid = 1'b1; refill_code = 4'd3; refill_count = 8'd250;
        tick();
        refill_valid = 1'b0;
        total++; if (dut.inv[2] !== 8'd255) begin $display("FAIL refill_saturate got=%0d want=255", dut.inv[2]); bad++; end
        refill_valid = 1'b1; refill_code = 4'd0; refill_count = 8'd5;
        tick();
        refill_code = 4'd7;
        tick();
        refill_valid = 1'b0;
        total++; if (dut.inv[0] !== 8'd10 || dut.inv[3] !== 8'd10) begin
            $display("FAIL refill_badcode got inv1=%0d inv10=%0d want 10/10", dut.inv[0], dut.inv[3]); bad++; end
        bus.change_ack = 1'b0;
        bus.change_req = 1'b1; bus.change_amount = 8'd1;
        tick();
        bus.change_req = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.o_change_valid) begin found = 1; break; end
        end
        bus.change_ack = 1'b1;
        refill_valid = 1'b1; refill_code = 4'd1; refill_count = 8'd3;
        tick();
        bus.change_ack = 1'b0;
        refill_valid = 1'b0;
        total++; if (found !== 1'b1 || dut.inv[0] !== 8'd12) begin
            $display("FAIL refill_with_dispense got found=%0b inv1=%0d want 1/12", found, dut.inv[0]); bad++; end
        repeat (4) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_exhaust();
        test_nochg();
        test_ack_hold();
        test_reset_mid();
`ifdef VM_CHANGE_REFILL_EN
        test_refill();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
